// File: rtl/nn_batch_runner_if.sv
// nn_batch_runner_if
//   Groups the memory, network and result signals of the batch runner.
//   master : runner side (drives read strobe, network input, results)
//   slave  : environment side (image/label memory, network, host start)
//
//   start                         host -> runner   begin a batch
//   imgRdEn / imgAddr             runner -> memory read strobe and image index
//   imgData / label               memory -> runner image word and expected class
//   NNin / NNreset / NNvalid      runner -> network input word, reset pulse, valid
//   maxIndex / maxValid           network -> runner argmax class and valid
//   busy / done                   runner status
//   resultValid / resultIndex / resultPred / resultCorrect / resultTimeout
//                                 per-image result, one-cycle pulse
//   correctCount / timeoutCount   batch totals
interface nn_batch_runner_if #(
    parameter int dataWidth  = 16,
    parameter int numInputs  = 784,
    parameter int numOutputs = 10,
    parameter int numImages  = 8
);
    localparam int labelWidth = (numOutputs > 1) ? $clog2(numOutputs) : 1;
    localparam int addrWidth  = (numImages > 1) ? $clog2(numImages) : 1;
    localparam int countWidth = $clog2(numImages + 1);

    logic                            start;
    logic                            imgRdEn;
    logic [addrWidth-1:0]            imgAddr;
    logic [numInputs*dataWidth-1:0]  imgData;
    logic [labelWidth-1:0]           label;
    logic [numInputs*dataWidth-1:0]  NNin;
    logic                            NNreset;
    logic                            NNvalid;
    logic [labelWidth-1:0]           maxIndex;
    logic                            maxValid;
    logic                            busy;
    logic                            done;
    logic                            resultValid;
    logic [addrWidth-1:0]            resultIndex;
    logic [labelWidth-1:0]           resultPred;
    logic                            resultCorrect;
    logic                            resultTimeout;
    logic [countWidth-1:0]           correctCount;
    logic [countWidth-1:0]           timeoutCount;

    modport master (
        input  start, imgData, label, maxIndex, maxValid,
        output imgRdEn, imgAddr, NNin, NNreset, NNvalid, busy, done,
               resultValid, resultIndex, resultPred, resultCorrect,
               resultTimeout, correctCount, timeoutCount
    );

    modport slave (
        output start, imgData, label, maxIndex, maxValid,
        input  imgRdEn, imgAddr, NNin, NNreset, NNvalid, busy, done,
               resultValid, resultIndex, resultPred, resultCorrect,
               resultTimeout, correctCount, timeoutCount
    );
endinterface

// File: rtl/nn_batch_runner.sv
// nn_batch_runner
//   Steps a batch of numImages images through a classifier network: reads
//   each image and label, presents the image to the network, waits for the
//   argmax (or a timeout), and reports per-image results and batch totals.
//
//   clk    sole clock, rising edge
//   reset  synchronous, active-high
//   bus    nn_batch_runner_if.master (see interface file for signal list)
//
//   state  | meaning
//   IDLE   | waiting for start after reset
//   READ   | imgRdEn high, memory fetching imgData/label for imgAddr
//   LOAD   | imgData/label valid, captured into NNin and label register
//   NNRST  | one-cycle network reset, RUN cycle counter cleared
//   RUN    | NNvalid high, waiting for maxValid or timeout
//   RECORD | resultValid pulse, totals updated, advance or finish
//   DONE   | batch finished, totals held, waiting for start
module nn_batch_runner #(
    parameter int dataWidth     = 16,
    parameter int numInputs     = 784,
    parameter int numOutputs    = 10,
    parameter int numImages     = 8,
    parameter int timeoutCycles = 4096
) (
    input  logic              clk,
    input  logic              reset,
    nn_batch_runner_if.master bus
);
    localparam int labelWidth = (numOutputs > 1) ? $clog2(numOutputs) : 1;
    localparam int addrWidth  = (numImages > 1) ? $clog2(numImages) : 1;
    localparam int countWidth = $clog2(numImages + 1);
    localparam int cntWidth   = $clog2(timeoutCycles + 1);
    localparam int imgWidth   = numInputs * dataWidth;

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_LOAD, S_NNRST, S_RUN, S_RECORD, S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [addrWidth-1:0]   addr_q, addr_d;
    logic [imgWidth-1:0]    nnin_q, nnin_d;
    logic [labelWidth-1:0]  label_q, label_d;
    logic [cntWidth-1:0]    cnt_q, cnt_d;
    logic [addrWidth-1:0]   ridx_q, ridx_d;
    logic [labelWidth-1:0]  rpred_q, rpred_d;
    logic                   rcorr_q, rcorr_d;
    logic                   rtmo_q, rtmo_d;
    logic [countWidth-1:0]  ccnt_q, ccnt_d;
    logic [countWidth-1:0]  tcnt_q, tcnt_d;
    logic                   rden_q, rden_d;
    logic                   nnrst_q, nnrst_d;
    logic                   nnvld_q, nnvld_d;
    logic                   rvld_q, rvld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        nnin_d  = nnin_q;
        label_d = label_q;
        cnt_d   = cnt_q;
        ridx_d  = ridx_q;
        rpred_d = rpred_q;
        rcorr_d = rcorr_q;
        rtmo_d  = rtmo_q;
        ccnt_d  = ccnt_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                    ccnt_d  = '0;
                    tcnt_d  = '0;
                end
            end
            S_READ: state_d = S_LOAD;
            S_LOAD: begin
                nnin_d  = bus.imgData;
                label_d = bus.label;
                state_d = S_NNRST;
            end
            S_NNRST: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // maxValid takes priority over the timeout on the final cycle
                if (bus.maxValid) begin
                    state_d = S_RECORD;
                    ridx_d  = addr_q;
                    rpred_d = bus.maxIndex;
                    rcorr_d = (bus.maxIndex == label_q);
                    rtmo_d  = 1'b0;
                end else if (cnt_q == cntWidth'(timeoutCycles - 1)) begin
                    state_d = S_RECORD;
                    ridx_d  = addr_q;
                    rpred_d = '0;
                    rcorr_d = 1'b0;
                    rtmo_d  = 1'b1;
                end
            end
            S_RECORD: begin
                ccnt_d = ccnt_q + countWidth'(rcorr_q);
                tcnt_d = tcnt_q + countWidth'(rtmo_q);
                if (addr_q == addrWidth'(numImages - 1)) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they are registered
        // and line up exactly with the state they belong to.
        rden_d  = (state_d == S_READ);
        nnrst_d = (state_d == S_NNRST);
        nnvld_d = (state_d == S_RUN);
        rvld_d  = (state_d == S_RECORD);
        busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            nnin_q  <= '0;
            label_q <= '0;
            cnt_q   <= '0;
            ridx_q  <= '0;
            rpred_q <= '0;
            rcorr_q <= 1'b0;
            rtmo_q  <= 1'b0;
            ccnt_q  <= '0;
            tcnt_q  <= '0;
            rden_q  <= 1'b0;
            nnrst_q <= 1'b0;
            nnvld_q <= 1'b0;
            rvld_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            nnin_q  <= nnin_d;
            label_q <= label_d;
            cnt_q   <= cnt_d;
            ridx_q  <= ridx_d;
            rpred_q <= rpred_d;
            rcorr_q <= rcorr_d;
            rtmo_q  <= rtmo_d;
            ccnt_q  <= ccnt_d;
            tcnt_q  <= tcnt_d;
            rden_q  <= rden_d;
            nnrst_q <= nnrst_d;
            nnvld_q <= nnvld_d;
            rvld_q  <= rvld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.imgRdEn       = rden_q;
    assign bus.imgAddr       = addr_q;
    assign bus.NNin          = nnin_q;
    assign bus.NNreset       = nnrst_q;
    assign bus.NNvalid       = nnvld_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.resultValid   = rvld_q;
    assign bus.resultIndex   = ridx_q;
    assign bus.resultPred    = rpred_q;
    assign bus.resultCorrect = rcorr_q;
    assign bus.resultTimeout = rtmo_q;
    assign bus.correctCount  = ccnt_q;
    assign bus.timeoutCount  = tcnt_q;
endmodule
